// File: rtl/imul_rr_arbiter.sv
// Round-robin front end for one registered unsigned array multiplier shared by NUM_REQ requesters.
// Each grant captures operands, spends one cycle in the array, then holds the product until it is accepted.
module imul_rr_arbiter #(
  parameter int unsigned NUM_BITS = 16,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           iReqValid,
  output logic [NUM_REQ-1:0]           oReqReady,
  input  logic [NUM_REQ*NUM_BITS-1:0]  iA,
  input  logic [NUM_REQ*NUM_BITS-1:0]  iB,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [2*NUM_BITS-1:0]        oResult,
  output logic [ID_W-1:0]              oId,
  output logic                         oBusy
);

  localparam int unsigned PROD_W = 2 * NUM_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] a_q, a_d;
  logic [NUM_BITS-1:0] b_q, b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [PROD_W-1:0]   result_q, result_d;
  logic [ID_W-1:0]     oid_q, oid_d;
  logic                valid_q, valid_d;

  logic                found_c;
  logic [ID_W-1:0]     gnt_id_c;
  logic [ID_W-1:0]     scan_id_c;
  logic [NUM_BITS-1:0] sel_a_c;
  logic [NUM_BITS-1:0] sel_b_c;
  logic [PROD_W-1:0]   prod_c;
  logic                grant_c;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found_c   = 1'b0;
    gnt_id_c  = '0;
    scan_id_c = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_id_c = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found_c && iReqValid[scan_id_c]) begin
        found_c  = 1'b1;
        gnt_id_c = scan_id_c;
      end
    end
  end

  // Operand mux for the winning slot.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_id_c == ID_W'(k)) begin
        sel_a_c = iA[k*NUM_BITS +: NUM_BITS];
        sel_b_c = iB[k*NUM_BITS +: NUM_BITS];
      end
    end
  end

  // The array sees only registered operands and its output is registered in MUL.
  assign prod_c  = PROD_W'(a_q) * PROD_W'(b_q);

  // Reset gates the grant so nothing looks accepted while the block is held in reset.
  assign grant_c = (state_q == ST_IDLE) && found_c && Reset;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    oid_d    = oid_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          a_d     = sel_a_c;
          b_d     = sel_b_c;
          id_d    = gnt_id_c;
          ptr_d   = gnt_id_c;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        result_d = prod_c;
        oid_d    = id_q;
        valid_d  = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      ptr_q    <= ID_W'(NUM_REQ - 1);
      result_q <= '0;
      oid_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      oid_q    <= oid_d;
      valid_q  <= valid_d;
    end
  end

  assign oReqReady = grant_c ? (NUM_REQ'(1) << gnt_id_c) : '0;
  assign oValid    = valid_q;
  assign oResult   = result_q;
  assign oId       = oid_q;
  assign oBusy     = (state_q != ST_IDLE);

endmodule
